// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and the wait counter sizing helper.
package apb_pkg;

    localparam int unsigned APB_A_WIDTH = 8;
    localparam int unsigned APB_D_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Wait counter must hold TIMEOUT itself; a disabled timeout still keeps a 1-bit counter.
    function automatic int unsigned wait_cnt_width(int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS-phase wait counter; flags the cycle in which the TIMEOUT-th wait would occur.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW = wait_cnt_width(TIMEOUT);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter reads k-1 in the k-th ACCESS cycle, so TIMEOUT-1 marks the last allowed cycle.
    assign expired_o = (TIMEOUT != 0) && (cnt_q >= CntLast);

endmodule

// File: rtl/apb_master.sv
// Command-to-APB bridge: sequences single read/write commands through IDLE/SETUP/ACCESS with timeout.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned A_WIDTH = APB_A_WIDTH,
    parameter int unsigned D_WIDTH = APB_D_WIDTH,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               p_clk,
    input  logic               p_rstn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [A_WIDTH-1:0] cmd_addr,
    input  logic [D_WIDTH-1:0] cmd_wdata,
    output logic               rsp_valid,
    output logic [D_WIDTH-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic               p_sel,
    output logic               p_enable,
    output logic               p_write,
    output logic [A_WIDTH-1:0] p_addr,
    output logic [D_WIDTH-1:0] wr_data,
    input  logic [D_WIDTH-1:0] rd_data,
    input  logic               p_ready
);

    apb_state_e state_q, state_d;

    logic               p_write_q;
    logic [A_WIDTH-1:0] p_addr_q;
    logic [D_WIDTH-1:0] wr_data_q;
    logic               rsp_valid_q;
    logic [D_WIDTH-1:0] rsp_rdata_q;
    logic               rsp_err_q;

    logic tmr_clear;
    logic tmr_enable;
    logic tmr_expired;
    logic accept;
    logic done;
    logic abort;

    assign accept = cmd_valid && cmd_ready;
    assign done   = (state_q == ACCESS) && p_ready;
    assign abort  = (state_q == ACCESS) && !p_ready && tmr_expired;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i     (p_clk),
        .rst_ni    (p_rstn),
        .clear_i   (tmr_clear),
        .enable_i  (tmr_enable),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge p_clk or negedge p_rstn) begin
        if (!p_rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = accept ? SETUP : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (p_ready) begin
                    state_d = accept ? SETUP : IDLE;
                end else if (tmr_expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        p_sel      = 1'b0;
        p_enable   = 1'b0;
        cmd_ready  = 1'b0;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
            end
            SETUP: begin
                p_sel     = 1'b1;
                tmr_clear = 1'b1;
            end
            ACCESS: begin
                p_sel      = 1'b1;
                p_enable   = 1'b1;
                cmd_ready  = p_ready;
                tmr_enable = !p_ready;
            end
            default: ;
        endcase
    end

    // On back-to-back, the response uses the outgoing p_write_q before the new command lands.
    always_ff @(posedge p_clk or negedge p_rstn) begin
        if (!p_rstn) begin
            p_write_q   <= 1'b0;
            p_addr_q    <= '0;
            wr_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                p_write_q <= cmd_write;
                p_addr_q  <= cmd_addr;
                wr_data_q <= cmd_wdata;
            end
            rsp_valid_q <= done || abort;
            if (done) begin
                rsp_rdata_q <= p_write_q ? '0 : rd_data;
                rsp_err_q   <= 1'b0;
            end else if (abort) begin
                rsp_rdata_q <= '0;
                rsp_err_q   <= 1'b1;
            end
        end
    end

    assign p_write   = p_write_q;
    assign p_addr    = p_addr_q;
    assign wr_data   = wr_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: queued commands, behavioural APB slave, per-cycle protocol checks.
module tb_apb_master;

    localparam int unsigned TO = 4;

    logic       p_clk = 1'b0;
    logic       p_rstn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       p_sel;
    logic       p_enable;
    logic       p_write;
    logic [7:0] p_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       p_ready;

    apb_master #(
        .A_WIDTH (8),
        .D_WIDTH (8),
        .TIMEOUT (TO)
    ) dut (
        .p_clk     (p_clk),
        .p_rstn    (p_rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .p_sel     (p_sel),
        .p_enable  (p_enable),
        .p_write   (p_write),
        .p_addr    (p_addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .p_ready   (p_ready)
    );

    always #5 p_clk = ~p_clk;

    int cyc = 0;
    always @(posedge p_clk) cyc <= cyc + 1;

    typedef struct {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         waits;
        logic       stuck;
        int         gap;
    } cmd_t;

    typedef struct {
        int         cyc;
        logic [7:0] rdata;
        logic       err;
        int         accs;
    } exp_t;

    cmd_t cmd_q[$];
    exp_t sb[$];
    cmd_t pend;
    cmd_t cur;

    int   n_checks = 0;
    int   n_errors = 0;
    int   acc_cnt  = 0;
    int   gap_cnt  = 0;
    logic acc_pending = 1'b0;
    logic prev_sel = 1'b0;
    logic [7:0] prev_addr = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    task automatic push_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                            input logic [7:0] rdata, input int waits, input logic stuck,
                            input int gap);
        cmd_t c;
        c.write = wr;  c.addr = addr;   c.wdata = wdata; c.rdata = rdata;
        c.waits = waits; c.stuck = stuck; c.gap = gap;
        cmd_q.push_back(c);
    endtask

    task automatic monitor();
        exp_t e;
        if (!p_sel) check_eq("en_without_sel", p_enable, 0);
        if (p_sel && !p_enable) check_eq("setup_addr", p_addr, cur.addr);
        if (p_enable) begin
            check_eq("en_after_setup", prev_sel, 1);
            check_eq("addr_stable", p_addr, prev_addr);
            check_eq("acc_write", p_write, cur.write);
            if (cur.write) check_eq("acc_wdata", wr_data, cur.wdata);
        end
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check_eq("rsp_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("rsp_cycle", cyc, e.cyc);
                check_eq("rsp_rdata", rsp_rdata, e.rdata);
                check_eq("rsp_err", rsp_err, e.err);
                check_eq("access_cycles", acc_cnt, e.accs);
                if (e.err) check_eq("idle_after_abort", p_sel, 0);
            end
        end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
            check_eq("rsp_missing", 0, 1);
            void'(sb.pop_front());
        end
        prev_sel  = p_sel;
        prev_addr = p_addr;
    endtask

    task automatic drive_slave();
        if (p_enable) begin
            acc_cnt++;
            p_ready = !cur.stuck && (acc_cnt > cur.waits);
            rd_data = p_ready ? cur.rdata : 8'hEE;
        end else begin
            acc_cnt = 0;
            p_ready = 1'($urandom_range(0, 1));
            rd_data = 8'($urandom);
        end
    endtask

    task automatic drive_cmd();
        exp_t e;
        if (acc_pending) begin
            acc_pending = 1'b0;
            cmd_valid   = 1'b0;
            gap_cnt     = 0;
        end else if (!cmd_valid) begin
            gap_cnt++;
        end
        if (!cmd_valid && cmd_q.size() != 0 && gap_cnt >= cmd_q[0].gap) begin
            pend      = cmd_q.pop_front();
            cmd_write = pend.write;
            cmd_addr  = pend.addr;
            cmd_wdata = pend.wdata;
            cmd_valid = 1'b1;
        end
        check_eq("cmd_ready", cmd_ready, (!p_sel) || (p_enable && p_ready));
        if (cmd_valid && cmd_ready) begin
            acc_pending = 1'b1;
            cur     = pend;
            e.cyc   = pend.stuck ? cyc + 2 + int'(TO) : cyc + 3 + pend.waits;
            e.accs  = pend.stuck ? int'(TO) : pend.waits + 1;
            e.rdata = (pend.stuck || pend.write) ? 8'h00 : pend.rdata;
            e.err   = pend.stuck;
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(negedge p_clk);
        monitor();
        drive_slave();
        #1;
        drive_cmd();
    endtask

    task automatic drain();
        int n = 0;
        while ((cmd_q.size() != 0 || cmd_valid || acc_pending || sb.size() != 0) && n < 300) begin
            step();
            n++;
        end
        check_eq("drain_in_time", (n < 300), 1);
        repeat (2) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        p_rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rd_data = '0; p_ready = 1'b0;
        cur = '{write: 1'b0, addr: 8'h00, wdata: 8'h00, rdata: 8'h00, waits: 0, stuck: 1'b0,
                gap: 0};
        pend = cur;
        #12;
        check_eq("rst_p_sel", p_sel, 0);
        check_eq("rst_p_enable", p_enable, 0);
        check_eq("rst_p_write", p_write, 0);
        check_eq("rst_p_addr", p_addr, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_rdata", rsp_rdata, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        @(negedge p_clk);
        p_rstn = 1'b1;

        // wr/addr/wdata/rdata/waits/stuck/gap
        push_cmd(1'b1, 8'h45, 8'hA5, 8'h00, 0, 1'b0, 0);
        drain();
        push_cmd(1'b0, 8'h65, 8'h00, 8'h3C, 2, 1'b0, 2);
        drain();
        push_cmd(1'b1, 8'h55, 8'h99, 8'h00, 0, 1'b0, 0);
        push_cmd(1'b0, 8'h76, 8'h00, 8'hC3, 0, 1'b0, 0);
        drain();
        push_cmd(1'b0, 8'h30, 8'h00, 8'h81, int'(TO) - 1, 1'b0, 1);
        push_cmd(1'b0, 8'h40, 8'h00, 8'h77, 0, 1'b1, 1);
        push_cmd(1'b1, 8'h41, 8'h17, 8'h00, 1, 1'b0, 0);
        drain();

        push_cmd(1'b0, 8'h50, 8'h00, 8'h66, 0, 1'b1, 0);
        n = 0;
        while (!p_enable && n < 50) begin
            step();
            n++;
        end
        check_eq("saw_access", p_enable, 1);
        step();
        #2;
        p_rstn = 1'b0;
        #1;
        check_eq("async_rst_sel", p_sel, 0);
        check_eq("async_rst_enable", p_enable, 0);
        check_eq("async_rst_rsp", rsp_valid, 0);
        sb.delete();
        cmd_q.delete();
        cmd_valid   = 1'b0;
        acc_pending = 1'b0;
        repeat (3) step();
        #1;
        p_rstn = 1'b1;
        push_cmd(1'b0, 8'h22, 8'h00, 8'h5A, 1, 1'b0, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

Command-to-APB bridge that sits directly upstream of the APB slave and drives its p_sel/p_enable/p_write/p_addr/wr_data inputs. It accepts single read or write commands on a valid/ready interface and sequences each one through the APB IDLE, SETUP and ACCESS phases. It honours slave wait states and aborts stalled transfers with a timeout. It returns a one-cycle response carrying read data and an error flag.

## Interface
- A_WIDTH, 8, address width
- D_WIDTH, 8, data width
- TIMEOUT, 16, max ACCESS cycles with p_ready low before abort; 0 disables timeout
- p_clk  in  1  clock, all logic on rising edge
- p_rstn  in  1  reset; asynchronous and active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  A_WIDTH  transfer address
- cmd_wdata  in  D_WIDTH  write data, ignored for reads
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  D_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  1 = transfer aborted by timeout
- p_sel  out  1  APB select
- p_enable  out  1  APB enable
- p_write  out  1  APB direction
- p_addr  out  A_WIDTH  APB address
- wr_data  out  D_WIDTH  APB write data
- rd_data  in  D_WIDTH  APB read data from slave
- p_ready  in  1  slave ready / wait-state control

## Operation
- States:
  - IDLE: p_sel=0, p_enable=0.
  - SETUP: p_sel=1, p_enable=0.
  - ACCESS: p_sel=1, p_enable=1.
- cmd_ready = (state==IDLE) || (state==ACCESS && p_ready). It is combinational on p_ready.
- On accept, cmd_write, cmd_addr and cmd_wdata are registered into p_write, p_addr and wr_data. The next state is SETUP.
- SETUP goes unconditionally to ACCESS after one cycle.
- ACCESS with p_ready=0 stays in ACCESS and increments the wait counter.
- ACCESS with p_ready=1 completes the transfer:
  - For reads, rd_data is captured into rsp_rdata. For writes, rsp_rdata is 0.
  - rsp_valid=1 and rsp_err=0 in the following cycle.
  - Next state is SETUP if a new command is accepted in the same cycle (back-to-back). Otherwise it is IDLE.
- Timeout (TIMEOUT>0): if p_ready is still 0 in the TIMEOUT-th ACCESS cycle, the transfer aborts.
  - The next cycle shows rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - The state goes to IDLE. cmd_ready stays 0 in the aborting cycle.
- Wait counter:
  - Cleared on entry to ACCESS.
  - Width $clog2(TIMEOUT+1), minimum 1 bit.
  - Saturates and never wraps.
- p_addr, p_write and wr_data hold from SETUP through the last ACCESS cycle. They keep their last values in IDLE.
- rsp_rdata and rsp_err hold their values after rsp_valid deasserts, until the next response.
- No response back-pressure. rsp_valid is a pulse the consumer must take.

## Timing
- Reset values:
  - State: IDLE.
  - All outputs 0: p_sel, p_enable, p_write, p_addr, wr_data, rsp_valid, rsp_rdata, rsp_err. cmd_ready is 1 once the state is IDLE.
  - Wait counter: 0.
- Reset mid-transfer: immediate asynchronous return to IDLE with the values above. No response is issued for the aborted command.
- Zero-wait latency, with accept at edge 0:
  - Cycle 1 is SETUP.
  - Cycle 2 is ACCESS, with p_ready sampled at the end of cycle 2.
  - rsp_valid is high in cycle 3.
- Each slave wait state adds one cycle.
- Back-to-back throughput: one transfer per 2 cycles (SETUP, ACCESS) with no intervening IDLE.
- p_enable never rises without p_sel having been 1 in the preceding SETUP cycle.
- p_sel=0 implies p_enable=0.

## Structure
- Shared package apb_pkg holds:
  - typedef enum logic [1:0] apb_state_e {IDLE=0, SETUP=1, ACCESS=2}.
  - Default widths A_WIDTH=8 and D_WIDTH=8, shared with the APB slave and its assertion module.
- Sub-module apb_wait_timer holds the wait counter:
  - Inputs: clear, enable, the TIMEOUT parameter.
  - Output: expired.
  - With TIMEOUT=0, expired is tied to 0.
- The master FSM and data registers live in apb_master.

## Test plan
- Reset then write: cmd write addr 'h45, wdata 'hA5, p_ready tied 1.
  - Required: SETUP then ACCESS with p_addr='h45 and wr_data='hA5.
  - rsp_valid in cycle 3 with rsp_err=0 and rsp_rdata=0.
- Read with 2 wait states: addr 'h65, p_ready low for 2 ACCESS cycles, then high with rd_data='h3C.
  - Required: p_sel/p_enable held for 3 ACCESS cycles.
  - rsp_rdata='h3C, rsp_valid in cycle 5.
- Back-to-back: write 'h55 then read 'h76 with cmd_valid held.
  - Required: second SETUP immediately follows the first ACCESS, with no IDLE cycle.
  - Two rsp_valid pulses 2 cycles apart.
- Timeout with TIMEOUT=4 and p_ready stuck at 0.
  - Required: exactly 4 ACCESS cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0, and state IDLE.
- Reset asserted during ACCESS.
  - Required: p_sel and p_enable go to 0 asynchronously, with no rsp_valid.
  - After release, a new read completes normally.
- Protocol check run throughout all scenarios: p_enable is only ever 1 one cycle or more after a SETUP cycle, and p_addr is stable while p_sel=1.
